// File: rtl/rle_pkg.sv
// Shared definitions for the RLE encode/decode path.
package rle_pkg;
  localparam int RLE_WIDTH = 8;
  localparam int RLE_CNT_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } rle_state_e;
endpackage

// File: rtl/rle_run_counter.sv
// Loadable down-counter tracking the samples left in the current run.
module rle_run_counter
  import rle_pkg::*;
#(
  parameter int CNT_W = RLE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] rem,
  output logic             is_last
);
  logic [CNT_W-1:0] rem_d, rem_q;

  // Load wins over decrement so a chained run can start on the last beat.
  always_comb begin
    rem_d = rem_q;
    if (load)     rem_d = load_val;
    else if (dec) rem_d = rem_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rem_q <= '0;
    else        rem_q <= rem_d;
  end

  assign rem     = rem_q;
  assign is_last = (rem_q == CNT_W'(1));
endmodule

// File: rtl/rle_decoder.sv
// Run-length expander: turns (value, count) pairs into count copies of value,
// one per cycle, chaining consecutive runs without bubbles.
module rle_decoder
  import rle_pkg::*;
#(
  parameter int WIDTH = RLE_WIDTH,
  parameter int CNT_W = RLE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [CNT_W-1:0] in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             zero_err
);
  rle_state_e       state_d, state_q;
  logic [WIDTH-1:0] val_d, val_q;
  logic             zero_err_d, zero_err_q;
  logic [CNT_W-1:0] rem;
  logic             is_last;
  logic             in_fire, out_fire, load, dec, zero_cnt;

  assign out_valid = (state_q == EXPAND);
  assign out_data  = val_q;
  assign out_last  = out_valid & is_last;
  assign out_fire  = out_valid & out_ready;
  // Next pair is taken in the final beat of the current run.
  assign in_ready  = (state_q == IDLE) | (out_fire & is_last);
  assign in_fire   = in_valid & in_ready;
  assign zero_cnt  = (in_count == '0);
  assign load      = in_fire & ~zero_cnt;
  assign dec       = out_fire & ~is_last;
  assign zero_err  = zero_err_q;

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    zero_err_d = in_fire & zero_cnt;
    if (load) begin
      state_d = EXPAND;
      val_d   = in_value;
    end else if (out_fire & is_last) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      val_q      <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      zero_err_q <= zero_err_d;
    end
  end

  rle_run_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dec      (dec),
    .load_val (in_count),
    .rem      (rem),
    .is_last  (is_last)
  );
endmodule

// File: tb/tb_rle_decoder.sv
// Bench for rle_decoder: a queue of pending samples models the expander.
module tb_rle_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_value = '0;
  logic [2:0] in_count = '0;
  logic       out_valid, out_ready = 1'b0, out_last, zero_err;
  logic [7:0] out_data;

  int cmp = 0, err = 0;

  rle_decoder #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_count(in_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .zero_err(zero_err)
  );

  always #5 clk = ~clk;

  // Reference: every accepted pair becomes count queued samples.
  typedef struct { logic [7:0] v; logic l; } smp_t;
  smp_t mq[$];
  bit   zpend = 0;
  logic e_rdy, e_valid, e_last, e_zerr;
  logic [7:0] e_data;

  // Called at a falling edge: apply inputs, then form expectations.
  task automatic drive(input logic v, input logic [7:0] val, input logic [2:0] c, input logic r);
    in_valid = v; in_value = val; in_count = c; out_ready = r;
    #1;
    e_valid = (mq.size() != 0);
    e_data  = e_valid ? mq[0].v : 8'h00;
    e_last  = e_valid && mq[0].l;
    e_rdy   = (mq.size() == 0) || (out_ready && mq.size() == 1);
    e_zerr  = zpend;
  endtask

  // Advance model across a rising edge; returns at the next falling edge.
  task automatic tick();
    bit ofire, ifire;
    logic [2:0] c;
    logic [7:0] v;
    ofire = e_valid && out_ready;
    ifire = in_valid && e_rdy;
    c = in_count; v = in_value;
    @(posedge clk);
    if (reset) begin
      if (ofire) void'(mq.pop_front());
      zpend = ifire && (c == 0);
      if (ifire && c != 0)
        for (int i = 0; i < int'(c); i++) mq.push_back('{v, (i == int'(c) - 1)});
    end else begin
      mq.delete();
      zpend = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_value = 8'd9; in_count = 3'd3; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || zero_err !== 1'b0 || out_last !== 1'b0) begin
        err++;
        $display("FAIL reset: rdy/vld/last/zerr/data=%b%b%b%b/%0d want 1000/0", in_ready, out_valid, out_last, zero_err, out_data);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    drive(0, 8'd0, 3'd0, 1);
    cmp++;
    if ({in_ready, out_valid, out_last, zero_err} !== {e_rdy, e_valid, e_last, e_zerr}) begin
      err++;
      $display("FAIL reset_idle: rdy/vld/last/zerr=%b%b%b%b want %b%b%b%b", in_ready, out_valid, out_last, zero_err, e_rdy, e_valid, e_last, e_zerr);
    end
    tick();
  endtask

  task automatic test_single();
    int beats = 0, lasts = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1, 8'hFB, 3'd3, 1);
      else        drive(0, 8'h00, 3'd0, 1);
      cmp++;
      if ({in_ready, out_valid, out_last, zero_err} !== {e_rdy, e_valid, e_last, e_zerr} || (e_valid && out_data !== e_data)) begin
        err++;
        $display("FAIL single: rdy/vld/last/zerr/data=%b%b%b%b/%0d want %b%b%b%b/%0d", in_ready, out_valid, out_last, zero_err, out_data, e_rdy, e_valid, e_last, e_zerr, e_data);
      end
      if (out_valid && out_data == 8'hFB) beats++;
      if (out_last) lasts++;
      tick();
    end
    cmp++;
    if (beats != 3 || lasts != 1) begin
      err++;
      $display("FAIL single_count: beats=%0d lasts=%0d want 3/1", beats, lasts);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3] = '{8'd7, 8'd9, 8'd4};
    logic [2:0] cnts [3] = '{3'd2, 3'd1, 3'd7};
    logic [7:0] want [10] = '{8'd7, 8'd7, 8'd9, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
    logic [7:0] got[$];
    int idx = 0, first = -1, lastc = -1;
    bit ok;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (idx < 3) drive(1, vals[idx], cnts[idx], 1);
      else         drive(0, 8'h00, 3'd0, 1);
      cmp++;
      if ({in_ready, out_valid, out_last, zero_err} !== {e_rdy, e_valid, e_last, e_zerr} || (e_valid && out_data !== e_data)) begin
        err++;
        $display("FAIL b2b: cyc %0d rdy/vld/last/zerr/data=%b%b%b%b/%0d want %b%b%b%b/%0d", cyc, in_ready, out_valid, out_last, zero_err, out_data, e_rdy, e_valid, e_last, e_zerr, e_data);
      end
      if (out_valid) begin
        got.push_back(out_data);
        if (first < 0) first = cyc;
        lastc = cyc;
      end
      if (idx < 3 && e_rdy) idx++;
      tick();
    end
    ok = (got.size() == 10) && (lastc - first + 1 == 10);
    if (ok) for (int i = 0; i < 10; i++) if (got[i] !== want[i]) ok = 0;
    cmp++;
    if (!ok) begin
      err++;
      $display("FAIL b2b_seq: got %0d samples over %0d cycles want 10 contiguous 7,7,9,4x7", got.size(), lastc - first + 1);
    end
  endtask

  task automatic test_backpressure();
    logic rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int fires = 0, lastfire = 0;
    drive(1, 8'd3, 3'd4, 1);
    tick();
    for (int k = 0; k < 7; k++) begin
      drive(0, 8'h00, 3'd0, rdy_pat[k]);
      cmp++;
      if ({in_ready, out_valid, out_last, zero_err} !== {e_rdy, e_valid, e_last, e_zerr} || (e_valid && out_data !== e_data)) begin
        err++;
        $display("FAIL bp: k %0d rdy/vld/last/zerr/data=%b%b%b%b/%0d want %b%b%b%b/%0d", k, in_ready, out_valid, out_last, zero_err, out_data, e_rdy, e_valid, e_last, e_zerr, e_data);
      end
      if (out_valid && out_ready && out_data == 8'd3) begin
        fires++;
        if (out_last) lastfire = fires;
      end
      tick();
    end
    drive(0, 8'h00, 3'd0, 1);
    cmp++;
    if (fires != 4 || lastfire != 4 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL bp_count: fires=%0d last_on=%0d vld=%b want 4/4/0", fires, lastfire, out_valid);
    end
    tick();
  endtask

  task automatic test_zero_count();
    int pulses = 0, samples = 0;
    bit offered = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 8'd6, 3'd0, 1);
      else        drive(0, 8'h00, 3'd0, 1);
      cmp++;
      if ({in_ready, out_valid, out_last, zero_err} !== {e_rdy, e_valid, e_last, e_zerr}) begin
        err++;
        $display("FAIL zero_idle: rdy/vld/last/zerr=%b%b%b%b want %b%b%b%b", in_ready, out_valid, out_last, zero_err, e_rdy, e_valid, e_last, e_zerr);
      end
      pulses += int'(zero_err);
      samples += int'(out_valid);
      tick();
    end
    cmp++;
    if (pulses != 1 || samples != 0) begin
      err++;
      $display("FAIL zero_idle_count: pulses=%0d samples=%0d want 1/0", pulses, samples);
    end
    pulses = 0; samples = 0;
    drive(1, 8'd1, 3'd2, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (!offered) drive(1, 8'd6, 3'd0, 1);
      else          drive(0, 8'h00, 3'd0, 1);
      cmp++;
      if ({in_ready, out_valid, out_last, zero_err} !== {e_rdy, e_valid, e_last, e_zerr} || (e_valid && out_data !== e_data)) begin
        err++;
        $display("FAIL zero_chain: i %0d rdy/vld/last/zerr/data=%b%b%b%b/%0d want %b%b%b%b/%0d", i, in_ready, out_valid, out_last, zero_err, out_data, e_rdy, e_valid, e_last, e_zerr, e_data);
      end
      if (in_valid && e_rdy) offered = 1;
      pulses += int'(zero_err);
      if (out_valid && out_data == 8'd1) samples++;
      tick();
    end
    cmp++;
    if (pulses != 1 || samples != 2 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL zero_chain_count: pulses=%0d ones=%0d vld=%b want 1/2/0", pulses, samples, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int twos = 0, fives = 0;
    drive(1, 8'd2, 3'd7, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 3'd0, 1);
      cmp++;
      if ({out_valid, out_last} !== {e_valid, e_last} || out_data !== e_data) begin
        err++;
        $display("FAIL midrst_pre: vld/last/data=%b%b/%0d want %b%b/%0d", out_valid, out_last, out_data, e_valid, e_last, e_data);
      end
      tick();
    end
    drive(0, 8'h00, 3'd0, 1);
    reset = 1'b0;
    #1;
    cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      err++;
      $display("FAIL midrst_async: vld/rdy/data=%b%b/%0d want 01/0", out_valid, in_ready, out_data);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1, 8'd5, 3'd1, 1);
      else        drive(0, 8'h00, 3'd0, 1);
      cmp++;
      if ({in_ready, out_valid, out_last, zero_err} !== {e_rdy, e_valid, e_last, e_zerr} || (e_valid && out_data !== e_data)) begin
        err++;
        $display("FAIL midrst_post: rdy/vld/last/zerr/data=%b%b%b%b/%0d want %b%b%b%b/%0d", in_ready, out_valid, out_last, zero_err, out_data, e_rdy, e_valid, e_last, e_zerr, e_data);
      end
      if (out_valid && out_data == 8'd2) twos++;
      if (out_valid && out_data == 8'd5) fives++;
      tick();
    end
    cmp++;
    if (twos != 0 || fives != 1) begin
      err++;
      $display("FAIL midrst_count: twos=%0d fives=%0d want 0/1", twos, fives);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
      cmp++;
      if ({in_ready, out_valid, out_last, zero_err} !== {e_rdy, e_valid, e_last, e_zerr} || (e_valid && out_data !== e_data)) begin
        err++;
        $display("FAIL random: i %0d rdy/vld/last/zerr/data=%b%b%b%b/%0d want %b%b%b%b/%0d", i, in_ready, out_valid, out_last, zero_err, out_data, e_rdy, e_valid, e_last, e_zerr, e_data);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_zero_count();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
